// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_typ_e;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side and line-side signals of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  RX_BUSY;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority vote.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_raw,
  input  logic                  count_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  fall,
  output logic                  bit_val,
  output logic                  resolve,
  output logic                  wrap
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx;
  logic                   rx_prev;
  logic                   s0;
  logic                   s1;
  logic [PRESCALE_W-1:0]  edge_cnt;
  logic [PRESCALE_W-1:0]  half;

  assign half    = prescale >> 1;
  assign rx      = sync[SYNC_STAGES-1];
  assign fall    = rx_prev & ~rx;
  assign wrap    = (edge_cnt == prescale - 1'b1);
  assign resolve = (edge_cnt == half + 1'b1);
  // third vote is the live sample on the resolve cycle
  assign bit_val = (s0 & s1) | (s0 & rx) | (s1 & rx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      s0       <= 1'b1;
      s1       <= 1'b1;
      edge_cnt <= '0;
    end else begin
      sync     <= SYNC_STAGES'({sync, rx_raw});
      rx_prev  <= rx;
      edge_cnt <= (count_en && !wrap) ? edge_cnt + 1'b1 : '0;
      if (edge_cnt == half - 1'b1) s0 <= rx;
      if (edge_cnt == half)        s1 <= rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shifter and parity/stop checking.
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | validating the start bit (glitch filter)
//   DATA   | shifting in data bits, LSB first
//   PARITY | checking the optional parity bit
//   STOP   | sampling the stop bit, then issuing the result
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 6
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  rx_state_e             state;
  logic [PRESCALE_W-1:0] cfg_p;
  logic [PRESCALE_W-1:0] p_legal;
  logic                  cfg_par_en;
  par_typ_e              cfg_par_typ;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad;
  logic                  fall;
  logic                  bit_val;
  logic                  resolve;
  logic                  wrap;
  logic                  start;
  logic                  leaving;
  logic                  count_en;

  assign p_legal = (bus.Prescale == PRESCALE_W'(PRESCALE_16) ||
                    bus.Prescale == PRESCALE_W'(PRESCALE_32)) ?
                   bus.Prescale : PRESCALE_W'(PRESCALE_8);

  assign start    = (state == IDLE) && fall;
  assign leaving  = resolve && ((state == STOP) || (state == START && bit_val));
  // counter restarts from 0 on every return to IDLE so a back-to-back edge lines up
  assign count_en = (state == IDLE) ? fall : !leaving;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES),
    .PRESCALE_W  (PRESCALE_W)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .rx_raw   (bus.RX_IN),
    .count_en (count_en),
    .prescale (cfg_p),
    .fall     (fall),
    .bit_val  (bit_val),
    .resolve  (resolve),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cfg_p          <= PRESCALE_W'(PRESCALE_8);
      cfg_par_en     <= 1'b0;
      cfg_par_typ    <= PAR_EVEN;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_bad        <= 1'b0;
      bus.P_DATA     <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      bus.RX_BUSY    <= 1'b0;
    end else begin
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      bus.RX_BUSY    <= (state != IDLE) || start;
      if (wrap) bit_cnt <= bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (fall) begin
            state       <= START;
            cfg_p       <= p_legal;
            cfg_par_en  <= bus.PAR_EN;
            cfg_par_typ <= par_typ_e'(bus.PAR_TYP);
            bit_cnt     <= '0;
            par_bad     <= 1'b0;
          end
        end
        START: begin
          if (resolve && bit_val) state <= IDLE;
          else if (wrap)          state <= DATA;
        end
        DATA: begin
          if (resolve) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          if (wrap && bit_cnt == BIT_W'(DATA_WIDTH))
            state <= cfg_par_en ? PARITY : STOP;
        end
        PARITY: begin
          if (resolve) par_bad <= bit_val ^ (^shreg) ^ (cfg_par_typ == PAR_ODD);
          if (wrap)    state   <= STOP;
        end
        STOP: begin
          if (resolve) begin
            bus.STP_ERR <= ~bit_val;
            bus.PAR_ERR <= par_bad;
            if (bit_val && !par_bad) begin
              bus.DATA_VALID <= 1'b1;
              bus.P_DATA     <= shreg;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, corner sequences, random frames.
module tb_uart_rx;

  typedef struct {
    int         cyc;
    logic [2:0] flags;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         p_cfg;
    int         p_line;
    logic [7:0] d;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stop;
    logic [2:0] flags;
    logic [7:0] data;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        got_q[$];
  logic [7:0] last_good;
  vec_t       tbl[8];

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) rx_bus ();

  uart_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rx_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (reset && (rx_bus.DATA_VALID || rx_bus.PAR_ERR || rx_bus.STP_ERR)) begin
      e.cyc   = cyc;
      e.flags = {rx_bus.DATA_VALID, rx_bus.PAR_ERR, rx_bus.STP_ERR};
      e.data  = rx_bus.P_DATA;
      obs_q.push_back(e);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input int p_cfg, input int p_line, input logic [7:0] d,
                            input bit pen, input bit ptyp, input bit pbit, input bit stop,
                            input int nbits, output int t0);
    logic [10:0] bits;
    int n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    n = 9;
    if (pen) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = stop;
    n++;
    if (nbits < n) n = nbits;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx_bus.RX_IN = bits[i];
      if (i == 0) begin
        t0 = cyc;
        rx_bus.Prescale = 6'(p_cfg);
        rx_bus.PAR_EN   = pen;
        rx_bus.PAR_TYP  = ptyp;
      end
      if (i == 2) begin
        rx_bus.Prescale = (p_cfg == 32) ? 6'd8 : 6'd32;
        rx_bus.PAR_EN   = ~pen;
        rx_bus.PAR_TYP  = ~ptyp;
      end
      repeat (p_line - 1) @(posedge clk);
    end
  endtask

  // Reference: result lands 2 sync clocks + stop index * P + P/2 + 2 after the line edge.
  task automatic model_frame(input int p_cfg, input logic [7:0] d, input bit pen,
                             input bit ptyp, input bit pbit, input bit stop, input int t0);
    int  p;
    bit  even_bit;
    bit  pe;
    bit  se;
    ev_t e;
    p = (p_cfg == 16 || p_cfg == 32) ? p_cfg : 8;
    even_bit = ($countones(d) % 2) == 1;
    pe = pen && (pbit != (even_bit ^ ptyp));
    se = !stop;
    e.cyc   = t0 + 2 + (pen ? 10 : 9) * p + p / 2 + 2;
    e.flags = {!pe && !se, pe, se};
    if (!pe && !se) last_good = d;
    e.data  = last_good;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string label);
    int waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({label, "_count"}, obs_q.size(), exp_q.size());
    got_q = obs_q;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_%0d_cyc", label, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_%0d_flags", label, i), int'(obs_q[i].flags), int'(exp_q[i].flags));
      check($sformatf("%s_%0d_data", label, i), int'(obs_q[i].data), int'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int t1;
    int busy_cnt;
    int last_busy;
    ev_t e;

    //          p_cfg p_line d      pen ptyp pbit stop flags   data
    tbl[0] = '{8,  8,  8'hA5, 1, 0, 0, 1, 3'b100, 8'hA5};
    tbl[1] = '{8,  8,  8'hA5, 1, 0, 1, 1, 3'b010, 8'hA5};
    tbl[2] = '{16, 16, 8'h3C, 0, 0, 0, 0, 3'b001, 8'hA5};
    tbl[3] = '{16, 16, 8'h55, 0, 0, 0, 1, 3'b100, 8'h55};
    tbl[4] = '{32, 32, 8'h0F, 1, 1, 1, 1, 3'b100, 8'h0F};
    tbl[5] = '{32, 32, 8'h07, 1, 1, 1, 1, 3'b010, 8'h0F};
    tbl[6] = '{12, 8,  8'hC3, 0, 0, 0, 1, 3'b100, 8'hC3};
    tbl[7] = '{8,  8,  8'h80, 1, 0, 0, 0, 3'b011, 8'hC3};

    rx_bus.RX_IN    = 1'b1;
    rx_bus.PAR_EN   = 1'b0;
    rx_bus.PAR_TYP  = 1'b0;
    rx_bus.Prescale = 6'd8;
    last_good       = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pdata", int'(rx_bus.P_DATA), 0);
    check("reset_flags", int'({rx_bus.DATA_VALID, rx_bus.PAR_ERR, rx_bus.STP_ERR, rx_bus.RX_BUSY}), 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].p_cfg, tbl[k].p_line, tbl[k].d, tbl[k].pen, tbl[k].ptyp,
                 tbl[k].pbit, tbl[k].stop, 99, t0);
      e.cyc   = t0 + 2 + (tbl[k].pen ? 10 : 9) * tbl[k].p_line + tbl[k].p_line / 2 + 2;
      e.flags = tbl[k].flags;
      e.data  = tbl[k].data;
      exp_q.push_back(e);
      last_good = tbl[k].data;
      if (!tbl[k].stop) begin
        repeat (40) @(posedge clk);
        #1 rx_bus.RX_IN = 1'b1;
      end
      repeat (2 * tbl[k].p_line) @(posedge clk);
      drain($sformatf("vec%0d", k));
      if (k == 0 && got_q.size() > 0) check("latency_88", got_q[0].cyc - t0, 88);
    end

    // two-clock low glitch at P=8
    rx_bus.Prescale = 6'd8;
    rx_bus.PAR_EN   = 1'b0;
    @(posedge clk);
    #1 rx_bus.RX_IN = 1'b0;
    t0 = cyc;
    repeat (2) @(posedge clk);
    #1 rx_bus.RX_IN = 1'b1;
    busy_cnt  = 0;
    last_busy = t0;
    repeat (30) begin
      @(negedge clk);
      if (rx_bus.RX_BUSY) begin
        busy_cnt++;
        last_busy = cyc;
      end
    end
    check("glitch_busy_seen", int'(busy_cnt > 0), 1);
    check("glitch_idle_in_8", int'(last_busy <= t0 + 10), 1);
    drain("glitch");

    // back-to-back at P=16 with Prescale scribbled mid-frame
    send_frame(16, 16, 8'h00, 0, 0, 0, 1, 99, t0);
    model_frame(16, 8'h00, 0, 0, 0, 1, t0);
    send_frame(16, 16, 8'hFF, 0, 0, 0, 1, 99, t1);
    model_frame(16, 8'hFF, 0, 0, 0, 1, t1);
    drain("b2b");
    if (got_q.size() == 2) check("b2b_spacing_160", got_q[1].cyc - got_q[0].cyc, 160);

    // reset during data bit 4 of 0x81 at P=32
    send_frame(32, 32, 8'h81, 0, 0, 0, 1, 5, t0);
    @(posedge clk);
    #1 rx_bus.RX_IN = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("busy_midframe", int'(rx_bus.RX_BUSY), 1);
    reset = 1'b0;
    #2;
    check("rst_mid_pdata", int'(rx_bus.P_DATA), 0);
    check("rst_mid_flags", int'({rx_bus.DATA_VALID, rx_bus.PAR_ERR, rx_bus.STP_ERR, rx_bus.RX_BUSY}), 0);
    rx_bus.RX_IN = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    last_good = 8'h00;
    repeat (40) @(posedge clk);
    drain("rst_abort");
    send_frame(32, 32, 8'h7E, 0, 0, 0, 1, 99, t0);
    model_frame(32, 8'h7E, 0, 0, 0, 1, t0);
    drain("rst_after");

    // random frames, mixed prescale/parity/errors/gaps
    for (int r = 0; r < 24; r++) begin
      int         p;
      logic [7:0] d;
      bit         pen;
      bit         ptyp;
      bit         pbit;
      bit         stop;
      p    = 8 << $urandom_range(0, 2);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = ((($countones(d) % 2) == 1) ^ ptyp) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(p, p, d, pen, ptyp, pbit, stop, 99, t0);
      model_frame(p, d, pen, ptyp, pbit, stop, t0);
      if (!stop) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 rx_bus.RX_IN = 1'b1;
        repeat (p) @(posedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    repeat (64) @(posedge clk);
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
